// File: rtl/sha256_mem_if.sv
// Host/memory bundle for the SHA-256/224 core.
// The master side is the host plus memory; the slave side is the core.
interface sha256_mem_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic              sha224;
   logic [31:0]       message_addr;
   logic [31:0]       size;
   logic [31:0]       output_addr;
   logic              done;
   logic              mem_clk;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;

   modport master (
      output start, sha224, message_addr, size, output_addr,
      output mem_read_data,
      input  done, mem_clk, mem_we, mem_addr, mem_write_data
   );

   modport slave (
      input  start, sha224, message_addr, size, output_addr,
      input  mem_read_data,
      output done, mem_clk, mem_we, mem_addr, mem_write_data
   );
endinterface

// File: rtl/sha256_mem_core.sv
// SHA-256/224 engine: reads and pads a byte message from memory,
// compresses UNROLL rounds per cycle and writes the digest back.
module sha256_mem_core #(
   parameter int ADDR_W = 16,
   parameter int UNROLL = 1
) (
   input  logic           clk,
   input  logic           reset,
   sha256_mem_if.slave    bus
);
   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8))
   begin : g_bad_unroll
      $error("UNROLL must be 1, 2, 4 or 8");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_COMP, S_UPD, S_WRITE, S_DONE
   } state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bs0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] bs1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   state_t            r_state, w_next;
   logic [5:0]        r_cnt;
   logic [27:0]       r_blk, r_nblk;
   logic [31:0]       r_size;
   logic [ADDR_W-1:0] r_maddr, r_oaddr, r_addr;
   logic              r_224, r_done, r_we;
   logic [31:0]       r_wdata;
   logic [31:0]       r_h [8];
   logic [31:0]       r_v [8];
   logic [31:0]       r_w [16];
   logic [31:0]       w_v_nxt [8];
   logic [31:0]       w_w_nxt [16];
   logic [31:0]       w_hsum [8];
   logic              w_last_blk, w_pvalid;
   logic [5:0]        w_nw_last;
   logic [31:0]       w_pg, w_psize, w_cword;
   logic [ADDR_W-1:0] w_pbase;
   logic [3:0]        w_cj;
   logic [2:0]        w_wi;
   logic [33:0]       w_cb, w_sz34, w_rem;
   logic              w_unused;

   assign w_unused = &{1'b0, bus.message_addr[31:ADDR_W],
                       bus.output_addr[31:ADDR_W]};

   assign bus.mem_clk        = clk;
   assign bus.done           = r_done;
   assign bus.mem_we         = r_we;
   assign bus.mem_addr       = r_addr;
   assign bus.mem_write_data = r_wdata;

   assign w_last_blk = (r_blk == r_nblk - 28'd1);
   assign w_nw_last  = r_224 ? 6'd6 : 6'd7;
   assign w_wi       = r_cnt[2:0] + 3'd1;
   assign w_cj       = r_cnt[3:0] - 4'd1;
   assign w_cb       = {r_blk, w_cj, 2'b00};
   assign w_sz34     = {2'b00, r_size};
   assign w_rem      = w_sz34 - w_cb;
   assign w_psize    = (r_state == S_IDLE) ? bus.size : r_size;
   assign w_pbase    = (r_state == S_IDLE) ?
                       bus.message_addr[ADDR_W-1:0] : r_maddr;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_next = S_LOAD;
         S_LOAD:  if (r_cnt == 6'd16) w_next = S_COMP;
         S_COMP:  if (r_cnt == 6'(64 - UNROLL)) w_next = S_UPD;
         S_UPD:   w_next = w_last_blk ? S_WRITE : S_LOAD;
         S_WRITE: if (r_cnt == w_nw_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Global word to present on the next cycle; fetched only if it holds message bytes
   always_comb begin
      unique case (r_state)
         S_IDLE:  w_pg = '0;
         S_UPD:   w_pg = {r_blk + 28'd1, 4'd0};
         default: w_pg = {r_blk, r_cnt[3:0]} + 32'd1;
      endcase
      w_pvalid = (w_next == S_LOAD) &&
                 (r_state != S_LOAD || r_cnt < 6'd15) &&
                 ({w_pg, 2'b00} < {2'b00, w_psize});
   end

   always_comb begin
      w_cword = '0;
      if (w_cb < w_sz34) begin
         unique case (1'b1)
            (w_rem > 34'd3):  w_cword = bus.mem_read_data;
            (w_rem == 34'd3): w_cword = {bus.mem_read_data[31:8], 8'h80};
            (w_rem == 34'd2): w_cword = {bus.mem_read_data[31:16], 16'h8000};
            default:          w_cword = {bus.mem_read_data[31:24], 24'h800000};
         endcase
      end else if (w_cb == w_sz34) begin
         w_cword = 32'h8000_0000;
      end
      if (w_last_blk && w_cj == 4'd14) w_cword = {29'd0, r_size[31:29]};
      if (w_last_blk && w_cj == 4'd15) w_cword = {r_size[28:0], 3'd0};
   end

   always_comb begin : rounds
      logic [31:0] w_vt [8];
      logic [31:0] w_wt [16];
      logic [31:0] w_t1, w_t2, w_wn;
      logic [5:0]  w_ki;
      w_vt = r_v;
      w_wt = r_w;
      w_t1 = '0;
      w_t2 = '0;
      w_wn = '0;
      w_ki = '0;
      for (int u = 0; u < UNROLL; u++) begin
         w_ki = r_cnt + 6'(u);
         w_t1 = w_vt[7] + bs1(w_vt[4]) + K[w_ki] + w_wt[0] +
                ((w_vt[4] & w_vt[5]) ^ (~w_vt[4] & w_vt[6]));
         w_t2 = bs0(w_vt[0]) + ((w_vt[0] & w_vt[1]) ^
                (w_vt[0] & w_vt[2]) ^ (w_vt[1] & w_vt[2]));
         w_wn = ss1(w_wt[14]) + w_wt[9] + ss0(w_wt[1]) + w_wt[0];
         for (int i = 7; i > 0; i--) w_vt[i] = w_vt[i-1];
         w_vt[4] = w_vt[4] + w_t1;
         w_vt[0] = w_t1 + w_t2;
         for (int i = 0; i < 15; i++) w_wt[i] = w_wt[i+1];
         w_wt[15] = w_wn;
      end
      w_v_nxt = w_vt;
      w_w_nxt = w_wt;
   end

   always_comb begin
      for (int i = 0; i < 8; i++) w_hsum[i] = r_h[i] + r_v[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_done  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
      end else begin
         r_done <= (w_next == S_DONE);
         r_we   <= 1'b0;
         if (w_pvalid) r_addr <= w_pbase + w_pg[ADDR_W-1:0];
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_224   <= bus.sha224;
                  r_size  <= bus.size;
                  r_maddr <= bus.message_addr[ADDR_W-1:0];
                  r_oaddr <= bus.output_addr[ADDR_W-1:0];
                  r_nblk  <= 28'((({1'b0, bus.size} + 33'd8) >> 6) + 33'd1);
                  r_blk   <= '0;
                  r_cnt   <= '0;
                  for (int i = 0; i < 8; i++)
                     r_h[i] <= bus.sha224 ? IV224[i] : IV256[i];
               end
            end
            S_LOAD: begin
               if (r_cnt != 6'd0) r_w[w_cj] <= w_cword;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'd16) begin
                  r_cnt <= '0;
                  r_v   <= r_h;
               end
            end
            S_COMP: begin
               r_v   <= w_v_nxt;
               r_w   <= w_w_nxt;
               r_cnt <= r_cnt + 6'(UNROLL);
            end
            S_UPD: begin
               for (int i = 0; i < 8; i++) r_h[i] <= w_hsum[i];
               r_cnt <= '0;
               r_blk <= r_blk + 28'd1;
               if (w_last_blk) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_oaddr;
                  r_wdata <= w_hsum[0];
               end
            end
            S_WRITE: begin
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt != w_nw_last) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_oaddr + ADDR_W'(w_wi);
                  r_wdata <= r_h[w_wi];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/sha256_mem_core.md
# sha256_mem_core

Parametrised SHA-256/SHA-224 hashing engine that reads a byte message from word-addressed single-port memory, pads it in hardware, compresses it in UNROLL rounds per cycle and writes the digest back to memory. It is the next-generation hash core in the design. Over the current engine it adds:
- configurable round unrolling and address width;
- run-time SHA-224 mode;
- on-the-fly padding across any block boundary;
- a complete digest write-back.

## Interface
Parameters:
- ADDR_W, 16: memory address width in words.
- UNROLL, 1: compression rounds per cycle; legal values 1, 2, 4, 8. Any other value is an elaboration error.

Ports:
- clk  in  1: single clock; mem_clk is driven from it.
- reset  in  1: synchronous, active-high reset.
- start  in  1: single-cycle request; sampled only in IDLE.
- sha224  in  1: mode select, sampled with start. 0 selects SHA-256, 1 selects SHA-224.
- message_addr  in  32: word address of message byte 0; bits [ADDR_W-1:0] are used.
- size  in  32: message length in bytes, sampled with start.
- output_addr  in  32: word address of the first digest word.
- done  out  1: one-cycle pulse when the digest is fully written.
- mem_clk  out  1: equal to clk.
- mem_we  out  1: write strobe.
- mem_addr  out  ADDR_W: memory address.
- mem_write_data  out  32: write data.
- mem_read_data  in  32: read data, valid one cycle after its address is presented.

## Operation
- Byte order: big-endian within a word. Byte 0 of the message is bits [31:24] of word 0.
- Block count: N = floor((size+8)/64) + 1, for example:
  - size 0..55 gives 1 block;
  - size 56..119 gives 2 blocks;
  - size 64 gives 2 blocks.
- IV:
  - SHA-256 uses the standard H0..H7 values, 6a09e667 through 5be0cd19.
  - SHA-224 uses c1059ed8, 367cd507, 3070dd17, f70e5939, ffc00b31, 68581511, 64f98fa7, befa4fa4.
- States: IDLE -> LOAD -> COMPUTE -> UPDATE -> (LOAD if blocks remain, else WRITE) -> DONE -> IDLE.
- LOAD: 17 cycles per block; word index j = 0..15 is presented on cycle j, and data is captured on cycle j+1.
  - Global word g = blk*16 + j.
  - If g*4 < size, mem_addr = message_addr + g. Addition is truncated modulo 2^ADDR_W, so addresses wrap.
  - If the word is a partial word, bytes at or past size are replaced by 0x80 followed by zeros.
  - If g*4 >= size, the word is synthesised with no read required. It is 0x80000000 when g*4 == size, else 0.
  - The last block's words 14 and 15 hold the 64-bit bit length: word 14 = size>>29, word 15 = size<<3 (low 32 bits).
- COMPUTE: 64/UNROLL cycles.
  - The message schedule uses a 16-entry rolling window, computing W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - Each cycle applies UNROLL chained rounds using K[t..t+UNROLL-1].
  - All arithmetic is mod 2^32.
- UPDATE: 1 cycle; H[i] <= H[i] + working[i].
- WRITE: NW cycles, where NW = 8 for SHA-256 and 7 for SHA-224.
  - Cycle i drives mem_we=1, mem_addr = output_addr + i (mod 2^ADDR_W), mem_write_data = H[i].
  - H7 is never written in SHA-224 mode.
- DONE: done=1 for exactly one cycle, then IDLE.

Boundary conditions:
- start is ignored while not in IDLE.
- An input change mid-hash has no effect; all inputs are captured at start.
- size = 0: a single block with word 0 = 0x80000000.
- reset asserted in any state: next state is IDLE, and done, mem_we, mem_addr and mem_write_data are all cleared, mid-block included. There is no partial-write recovery.

## Timing
- Reset values: done=0, mem_we=0, mem_addr=0, mem_write_data=0, state IDLE.
- mem_we is 1 only in WRITE.
- In IDLE, COMPUTE, UPDATE and DONE, mem_addr holds its last value and mem_we=0.
- Latency from the edge sampling start to the edge that asserts done: N*(18 + 64/UNROLL) + NW cycles.
  - UNROLL=1, one block, SHA-256: 90 cycles.
- Back-to-back operation: a start in the cycle after done is accepted.

## Test plan
- "abc": size=3, word 0x61626300 at message_addr, SHA-256, UNROLL=1.
  - Required digest at output_addr..+7: ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - done arrives 90 cycles after start.
- Same "abc" message with sha224=1.
  - Required digest, 7 words: 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
  - output_addr+7 must be untouched.
- size=0, SHA-256: digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with no mem read issued.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (2 blocks), run at UNROLL=1, 2, 4 and 8.
  - Digest for all four: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Latency must match the formula for each UNROLL.
- Address wrap: message_addr = 2^ADDR_W - 1 holding "abc" and output_addr = 2^ADDR_W - 3.
  - Required: the same "abc" digest.
  - Writes appear at addresses FFFD, FFFE, FFFF, 0000, ... .
- Reset asserted during COMPUTE, then start "abc" again.
  - Required: mem_we=0 and done=0 on the cycle after reset.
  - The second hash gives the correct "abc" digest.
  - A start pulse held during the busy period is ignored.
